// File: rtl/pid_pkg.sv
// Shared types, constants and saturation helper for the PID speed controller.
package pid_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MP,
        S_MI,
        S_MD,
        S_OUT
    } pid_state_t;

    // Gains are unsigned Q8.8 with the default FRAC_BITS; 0x0100 is unity.
    localparam logic [15:0] KP_DEFAULT = 16'h0100;
    localparam logic [15:0] KI_DEFAULT = 16'h0000;
    localparam logic [15:0] KD_DEFAULT = 16'h0000;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input logic signed [63:0] lim);
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction

endpackage

// File: rtl/pid_speed_ctrl_mac.sv
// Registered signed x unsigned multiply-accumulate shared by the P, I and D terms.
module pid_mac #(
    parameter int A_WIDTH   = 33,
    parameter int G_WIDTH   = 16,
    parameter int ACC_WIDTH = 51
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clr_i,
    input  logic                        acc_i,
    input  logic signed [A_WIDTH-1:0]   a_i,
    input  logic        [G_WIDTH-1:0]   b_i,
    output logic signed [ACC_WIDTH-1:0] acc_o
);

    logic signed [A_WIDTH+G_WIDTH:0] prod;
    logic signed [ACC_WIDTH-1:0]     acc_q;

    // Gain is zero-extended so it multiplies as a non-negative signed value.
    assign prod  = a_i * $signed({1'b0, b_i});
    assign acc_o = acc_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            acc_q <= '0;
        else if (clr_i)
            acc_q <= ACC_WIDTH'(prod);
        else if (acc_i)
            acc_q <= acc_q + ACC_WIDTH'(prod);
    end

endmodule

// File: rtl/pid_speed_ctrl.sv
// Closed-loop speed PID: one RPM sample in, one saturated signed command out,
// with a fixed 5-cycle latency through a single shared MAC.
module pid_speed_ctrl
    import pid_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int GAIN_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int INTEG_LIMIT = 100_000,
    parameter int OUT_MAX     = 1000
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] setpoint_i,
    input  logic        [GAIN_WIDTH-1:0] kp_i,
    input  logic        [GAIN_WIDTH-1:0] ki_i,
    input  logic        [GAIN_WIDTH-1:0] kd_i,
    input  logic                         rpm_valid_i,
    input  logic signed [DATA_WIDTH-1:0] rpm_data_i,
    output logic                         ctrl_valid_o,
    output logic signed [OUT_WIDTH-1:0]  ctrl_data_o,
    output logic                         busy_o
);

    localparam int EW  = DATA_WIDTH + 1;
    localparam int OPW = ACC_WIDTH + 1;
    localparam int MW  = ACC_WIDTH + GAIN_WIDTH + 3;

    pid_state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] sp_q, rpm_q;
    logic        [GAIN_WIDTH-1:0] kp_q, ki_q, kd_q;
    logic signed [EW-1:0]         err_c, err_q, prev_err_q;
    logic signed [OPW-1:0]        derr_c, derr_q, integ_sum;
    logic signed [ACC_WIDTH-1:0]  integ_q, integ_c;

    logic                         mac_clr, mac_acc;
    logic signed [OPW-1:0]        mac_a;
    logic        [GAIN_WIDTH-1:0] mac_b;
    logic signed [MW-1:0]         mac_q, y_shift;
    logic signed [OUT_WIDTH-1:0]  y_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (rpm_valid_i) state_d = S_ERR;
                S_ERR:   state_d = S_MP;
                S_MP:    state_d = S_MI;
                S_MI:    state_d = S_MD;
                S_MD:    state_d = S_OUT;
                S_OUT:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != S_IDLE);

    // Error terms are widened before subtracting so no intermediate can wrap.
    assign err_c     = EW'(sp_q) - EW'(rpm_q);
    assign derr_c    = OPW'(err_c) - OPW'(prev_err_q);
    assign integ_sum = OPW'(integ_q) + OPW'(err_c);
    assign integ_c   = ACC_WIDTH'(sat_signed(64'(integ_sum), 64'(INTEG_LIMIT)));

    always_comb begin
        mac_clr = 1'b0;
        mac_acc = 1'b0;
        mac_a   = '0;
        mac_b   = '0;
        case (state_q)
            S_MP: begin
                mac_clr = 1'b1;
                mac_a   = OPW'(err_q);
                mac_b   = kp_q;
            end
            S_MI: begin
                mac_acc = 1'b1;
                mac_a   = OPW'(integ_q);
                mac_b   = ki_q;
            end
            S_MD: begin
                mac_acc = 1'b1;
                mac_a   = derr_q;
                mac_b   = kd_q;
            end
            default: ;
        endcase
    end

    pid_mac #(
        .A_WIDTH   (OPW),
        .G_WIDTH   (GAIN_WIDTH),
        .ACC_WIDTH (MW)
    ) u_mac (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (mac_clr),
        .acc_i (mac_acc),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .acc_o (mac_q)
    );

    assign y_shift = mac_q >>> FRAC_BITS;
    assign y_c     = OUT_WIDTH'(sat_signed(64'(y_shift), 64'(OUT_MAX)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp_q         <= '0;
            rpm_q        <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            kd_q         <= '0;
            err_q        <= '0;
            derr_q       <= '0;
            prev_err_q   <= '0;
            integ_q      <= '0;
            ctrl_data_o  <= '0;
            ctrl_valid_o <= 1'b0;
        end else if (!en_i) begin
            integ_q      <= '0;
            prev_err_q   <= '0;
            ctrl_data_o  <= '0;
            ctrl_valid_o <= 1'b0;
        end else begin
            ctrl_valid_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rpm_valid_i) begin
                        sp_q  <= setpoint_i;
                        rpm_q <= rpm_data_i;
                        kp_q  <= kp_i;
                        ki_q  <= ki_i;
                        kd_q  <= kd_i;
                    end
                end
                S_ERR: begin
                    err_q      <= err_c;
                    derr_q     <= derr_c;
                    integ_q    <= integ_c;
                    prev_err_q <= err_c;
                end
                S_OUT: begin
                    ctrl_data_o  <= y_c;
                    ctrl_valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_speed_ctrl.sv
// Directed-vector bench for pid_speed_ctrl (integrator limit overridden to 25).
module tb_pid_speed_ctrl;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               en_i = 1'b0;
    logic signed [15:0] setpoint_i = '0;
    logic        [15:0] kp_i = '0;
    logic        [15:0] ki_i = '0;
    logic        [15:0] kd_i = '0;
    logic               rpm_valid_i = 1'b0;
    logic signed [15:0] rpm_data_i = '0;
    logic               ctrl_valid_o;
    logic signed [15:0] ctrl_data_o;
    logic               busy_o;

    int n_vec = 0;
    int n_err = 0;

    pid_speed_ctrl #(
        .INTEG_LIMIT (25)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en_i         (en_i),
        .setpoint_i   (setpoint_i),
        .kp_i         (kp_i),
        .ki_i         (ki_i),
        .kd_i         (kd_i),
        .rpm_valid_i  (rpm_valid_i),
        .rpm_data_i   (rpm_data_i),
        .ctrl_valid_o (ctrl_valid_o),
        .ctrl_data_o  (ctrl_data_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge right after the sampling rising edge.
    task automatic send_only(input int sp, input int rpm,
                             input logic [15:0] kp, input logic [15:0] ki, input logic [15:0] kd);
        @(negedge clk);
        setpoint_i  = 16'(sp);
        rpm_data_i  = 16'(rpm);
        kp_i        = kp;
        ki_i        = ki;
        kd_i        = kd;
        rpm_valid_i = 1'b1;
        @(negedge clk);
        rpm_valid_i = 1'b0;
    endtask

    task automatic run_vec(input string tag, input int sp, input int rpm,
                           input logic [15:0] kp, input logic [15:0] ki, input logic [15:0] kd,
                           input int exp);
        int lat;
        lat = 99;
        send_only(sp, rpm, kp, ki, kd);
        chk({tag, "_busy"}, longint'(busy_o), 1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ctrl_valid_o) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 5);
        chk(tag, longint'(ctrl_data_o), exp);
        @(negedge clk);
        chk({tag, "_pulse"}, longint'(ctrl_valid_o), 0);
    endtask

    task automatic clear_loop();
        @(negedge clk);
        en_i = 1'b0;
        @(negedge clk);
        en_i = 1'b1;
    endtask

    initial begin
        int pulses;
        int first_val;

        repeat (2) @(negedge clk);
        chk("rst_valid", longint'(ctrl_valid_o), 0);
        chk("rst_data", longint'(ctrl_data_o), 0);
        chk("rst_busy", longint'(busy_o), 0);
        rstn = 1'b1;
        en_i = 1'b1;

        // Proportional only
        run_vec("p_basic", 100, 40, 16'h0100, 16'h0, 16'h0, 60);
        run_vec("p_neg_rpm", -20, -100, 16'h0100, 16'h0, 16'h0, 80);

        // Sign, saturation and floor rounding
        run_vec("p_sign", -50, 50, 16'h0200, 16'h0, 16'h0, -200);
        run_vec("p_sat_pos", 3000, 0, 16'h0200, 16'h0, 16'h0, 1000);
        run_vec("p_sat_neg", -3000, 0, 16'h0200, 16'h0, 16'h0, -1000);
        run_vec("p_floor_neg", -3, 0, 16'h0080, 16'h0, 16'h0, -2);
        run_vec("p_floor_pos", 3, 0, 16'h0080, 16'h0, 16'h0, 1);

        // Integrator with clamp at 25
        clear_loop();
        run_vec("i_1", 10, 0, 16'h0, 16'h0100, 16'h0, 10);
        run_vec("i_2", 10, 0, 16'h0, 16'h0100, 16'h0, 20);
        run_vec("i_3_clamp", 10, 0, 16'h0, 16'h0100, 16'h0, 25);
        run_vec("i_4_pinned", 10, 0, 16'h0, 16'h0100, 16'h0, 25);
        run_vec("i_neg_clamp", -100, 0, 16'h0, 16'h0100, 16'h0, -25);

        // Derivative
        clear_loop();
        run_vec("d_1", 10, 0, 16'h0, 16'h0, 16'h0100, 10);
        run_vec("d_2", 30, 0, 16'h0, 16'h0, 16'h0100, 20);
        run_vec("d_flat", 30, 0, 16'h0, 16'h0, 16'h0100, 0);
        run_vec("d_neg", 0, 0, 16'h0, 16'h0, 16'h0100, -30);

        // Abort while in MI
        clear_loop();
        run_vec("abort_pre", 50, 0, 16'h0100, 16'h0, 16'h0, 50);
        send_only(50, 0, 16'h0100, 16'h0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_mi", longint'(busy_o), 1);
        en_i = 1'b0;
        @(negedge clk);
        chk("abort_busy", longint'(busy_o), 0);
        chk("abort_data", longint'(ctrl_data_o), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (ctrl_valid_o) pulses++;
            @(negedge clk);
        end
        chk("abort_no_valid", pulses, 0);
        en_i = 1'b1;
        // integ and prev_err must both restart from zero: 10 + (10 - 0)
        run_vec("abort_post", 10, 0, 16'h0, 16'h0100, 16'h0100, 20);

        // Overrun: extra samples while busy and in OUT are dropped
        clear_loop();
        send_only(70, 0, 16'h0100, 16'h0, 16'h0);
        pulses    = 0;
        first_val = -9999;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (ctrl_valid_o) begin
                pulses++;
                if (pulses == 1) first_val = int'(ctrl_data_o);
            end
            if (i == 1 || i == 4) begin
                setpoint_i  = 16'sd500;
                kp_i        = 16'h0200;
                rpm_valid_i = 1'b1;
            end else begin
                rpm_valid_i = 1'b0;
            end
        end
        chk("ovr_pulses", pulses, 1);
        chk("ovr_value", first_val, 70);
        chk("ovr_idle", longint'(busy_o), 0);

        // Asynchronous reset mid-calculation
        send_only(123, 0, 16'h0100, 16'h0, 16'h0);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("arst_data", longint'(ctrl_data_o), 0);
        chk("arst_valid", longint'(ctrl_valid_o), 0);
        chk("arst_busy", longint'(busy_o), 0);
        @(negedge clk);
        rstn = 1'b1;
        run_vec("arst_recover", 5, -5, 16'h0100, 16'h0, 16'h0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
